// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: aligns and extends load data from a variable-latency
// data memory, selects the write-back value and registers it into the WB slot.
// A load whose data is not yet valid parks the stage in WAIT and stalls
// upstream until the data arrives, the slot is flushed, or the wait times out.
module mem_wb_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic                            is_load,
    input  logic [2:0]                      dm_ctrl,
    input  logic [$clog2(XLEN/8)-1:0]       bias,
    input  logic                            RegWrite_in,
    input  logic [RA_W-1:0]                 rd_in,
    input  logic [1:0]                      WDSel_in,
    input  logic [XLEN-1:0]                 WD_in,
    input  logic                            flush,
    input  logic                            mem_rvalid,
    input  logic [XLEN-1:0]                 mem_rdata,
    output logic                            stall_req,
    output logic                            wb_valid,
    output logic                            RegWrite,
    output logic [RA_W-1:0]                 rd,
    output logic [XLEN-1:0]                 WD,
    output logic                            mis_align,
    output logic                            bus_err
);

    localparam int unsigned BW    = $clog2(XLEN / 8);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] DM_W   = 3'b000;
    localparam logic [2:0] DM_H   = 3'b001;
    localparam logic [2:0] DM_B   = 3'b010;
    localparam logic [2:0] DM_HU  = 3'b011;
    localparam logic [2:0] DM_BU  = 3'b100;
    localparam logic [2:0] DM_D   = 3'b101;
    localparam logic [2:0] DM_WU  = 3'b110;

    localparam logic [1:0] WDSEL_MEM = 2'b01;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;

    // control captured when a load has to wait for its data
    logic [2:0]        cap_ctrl_q;
    logic [BW-1:0]     cap_bias_q;
    logic              cap_regwrite_q;
    logic [RA_W-1:0]   cap_rd_q;
    logic [1:0]        cap_wdsel_q;

    logic              wb_valid_q;
    logic              regwrite_q;
    logic [RA_W-1:0]   rd_q;
    logic [XLEN-1:0]   wd_q;
    logic              mis_align_q;
    logic              bus_err_q;

    logic [2:0]        sel_ctrl;
    logic [BW-1:0]     sel_bias;
    logic              sel_regwrite;
    logic [RA_W-1:0]   sel_rd;
    logic [1:0]        sel_wdsel;
    logic              ret_is_load;

    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   extracted;
    logic              misaligned;
    logic [XLEN-1:0]   wd_w;
    logic              timed_out;

    // Retire control comes from the live inputs in IDLE, from the captured copy in WAIT
    always_comb begin
        sel_ctrl     = dm_ctrl;
        sel_bias     = bias;
        sel_regwrite = RegWrite_in;
        sel_rd       = rd_in;
        sel_wdsel    = WDSel_in;
        ret_is_load  = is_load;
        if (state_q == S_WAIT) begin
            sel_ctrl     = cap_ctrl_q;
            sel_bias     = cap_bias_q;
            sel_regwrite = cap_regwrite_q;
            sel_rd       = cap_rd_q;
            sel_wdsel    = cap_wdsel_q;
            ret_is_load  = 1'b1;
        end
    end

    // Shift the addressed bytes down, then size and sign/zero-extend
    always_comb begin
        shifted   = mem_rdata >> {sel_bias, 3'b000};
        extracted = '0;
        case (sel_ctrl)
            DM_W:    extracted = XLEN'($signed(shifted[31:0]));
            DM_H:    extracted = XLEN'($signed(shifted[15:0]));
            DM_B:    extracted = XLEN'($signed(shifted[7:0]));
            DM_HU:   extracted = XLEN'(shifted[15:0]);
            DM_BU:   extracted = XLEN'(shifted[7:0]);
            DM_D:    extracted = (XLEN == 64) ? shifted : '0;
            DM_WU:   extracted = (XLEN == 64) ? XLEN'(shifted[31:0]) : '0;
            default: extracted = '0;
        endcase
    end

    // Natural-alignment check on the access size
    always_comb begin
        misaligned = 1'b0;
        case (sel_ctrl)
            DM_H, DM_HU: misaligned = sel_bias[0];
            DM_W, DM_WU: misaligned = (sel_bias[1:0] != 2'b00);
            DM_D:        misaligned = (sel_bias != '0);
            default:     misaligned = 1'b0;
        endcase
    end

    // Write-back value select
    always_comb begin
        wd_w = (sel_wdsel == WDSEL_MEM) ? extracted : WD_in;
    end

    assign timed_out = (cnt_q >= CNT_W'(TIMEOUT));

    // Upstream must hold while a load is waiting; drops the cycle data arrives
    assign stall_req = ((state_q == S_IDLE) && in_valid && is_load && !mem_rvalid && !flush)
                    || ((state_q == S_WAIT) && !mem_rvalid && !flush && !timed_out);

    // Stage FSM with registered WB outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            cap_ctrl_q     <= '0;
            cap_bias_q     <= '0;
            cap_regwrite_q <= 1'b0;
            cap_rd_q       <= '0;
            cap_wdsel_q    <= '0;
            wb_valid_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            rd_q           <= '0;
            wd_q           <= '0;
            mis_align_q    <= 1'b0;
            bus_err_q      <= 1'b0;
        end else begin
            // pulses and the slot default to a bubble unless a retire happens
            mis_align_q <= 1'b0;
            bus_err_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            regwrite_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        if (!is_load || mem_rvalid) begin
                            wb_valid_q  <= 1'b1;
                            regwrite_q  <= sel_regwrite & ~misaligned;
                            rd_q        <= sel_rd;
                            wd_q        <= wd_w;
                            mis_align_q <= misaligned & ret_is_load;
                        end else begin
                            cap_ctrl_q     <= dm_ctrl;
                            cap_bias_q     <= bias;
                            cap_regwrite_q <= RegWrite_in;
                            cap_rd_q       <= rd_in;
                            cap_wdsel_q    <= WDSel_in;
                            cnt_q          <= CNT_W'(1);
                            state_q        <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (mem_rvalid) begin
                        wb_valid_q  <= 1'b1;
                        regwrite_q  <= sel_regwrite & ~misaligned;
                        rd_q        <= sel_rd;
                        wd_q        <= wd_w;
                        mis_align_q <= misaligned & ret_is_load;
                        cnt_q       <= '0;
                        state_q     <= S_IDLE;
                    end else if (timed_out) begin
                        bus_err_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb_valid  = wb_valid_q;
    assign RegWrite  = regwrite_q;
    assign rd        = rd_q;
    assign WD        = wd_q;
    assign mis_align = mis_align_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a 32-bit instance for the main sequences and
// a 64-bit instance for the wide load codes and asynchronous reset mid-wait.
module tb_mem_wb_stage;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] wd;
        logic        mis;
        logic        err;
        logic        dat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    exp_t qa[$];
    exp_t qb[$];

    // 32-bit instance
    logic        a_rst, a_in_valid, a_is_load, a_rw_in, a_flush, a_rvalid;
    logic [2:0]  a_dm;
    logic [1:0]  a_bias, a_wdsel;
    logic [4:0]  a_rd_in;
    logic [31:0] a_wd_in, a_rdata;
    logic        a_stall, a_wbv, a_rw, a_mis, a_err;
    logic [4:0]  a_rd;
    logic [31:0] a_wd;

    mem_wb_stage #(.XLEN(32), .RA_W(5), .TIMEOUT(15)) u_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .is_load(a_is_load),
        .dm_ctrl(a_dm), .bias(a_bias), .RegWrite_in(a_rw_in), .rd_in(a_rd_in),
        .WDSel_in(a_wdsel), .WD_in(a_wd_in), .flush(a_flush),
        .mem_rvalid(a_rvalid), .mem_rdata(a_rdata), .stall_req(a_stall),
        .wb_valid(a_wbv), .RegWrite(a_rw), .rd(a_rd), .WD(a_wd),
        .mis_align(a_mis), .bus_err(a_err)
    );

    // 64-bit instance
    logic        b_rst, b_in_valid, b_is_load, b_rw_in, b_flush, b_rvalid;
    logic [2:0]  b_dm;
    logic [2:0]  b_bias;
    logic [1:0]  b_wdsel;
    logic [4:0]  b_rd_in;
    logic [63:0] b_wd_in, b_rdata;
    logic        b_stall, b_wbv, b_rw, b_mis, b_err;
    logic [4:0]  b_rd;
    logic [63:0] b_wd;

    mem_wb_stage #(.XLEN(64), .RA_W(5), .TIMEOUT(4)) u_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .is_load(b_is_load),
        .dm_ctrl(b_dm), .bias(b_bias), .RegWrite_in(b_rw_in), .rd_in(b_rd_in),
        .WDSel_in(b_wdsel), .WD_in(b_wd_in), .flush(b_flush),
        .mem_rvalid(b_rvalid), .mem_rdata(b_rdata), .stall_req(b_stall),
        .wb_valid(b_wbv), .RegWrite(b_rw), .rd(b_rd), .WD(b_wd),
        .mis_align(b_mis), .bus_err(b_err)
    );

    function automatic exp_t mk(input logic v, input logic rw, input logic [4:0] rd,
                                input logic [63:0] wd, input logic mis, input logic err);
        exp_t e;
        e.v = v; e.rw = rw; e.rd = rd; e.wd = wd; e.mis = mis; e.err = err; e.dat = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub(input logic err);
        exp_t e;
        e = mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, err);
        e.dat = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string pfx, input exp_t x, input logic v, input logic rw,
                       input logic [4:0] r, input logic [63:0] w, input logic m, input logic e);
        chk({pfx, "_wb_valid"}, 64'(v), 64'(x.v));
        chk({pfx, "_RegWrite"}, 64'(rw), 64'(x.rw));
        chk({pfx, "_mis_align"}, 64'(m), 64'(x.mis));
        chk({pfx, "_bus_err"}, 64'(e), 64'(x.err));
        if (x.dat) begin
            chk({pfx, "_rd"}, 64'(r), 64'(x.rd));
            chk({pfx, "_WD"}, w, x.wd);
        end
    endtask

    // One cycle on instance A: check stall, push expectation, clock, pop and compare
    task automatic cyc_a(input string tag, input logic exp_stall, input exp_t e);
        exp_t x;
        #1;
        chk({tag, "_stall"}, 64'(a_stall), 64'(exp_stall));
        qa.push_back(e);
        @(posedge clk);
        #1;
        x = qa.pop_front();
        cmp(tag, x, a_wbv, a_rw, a_rd, 64'(a_wd), a_mis, a_err);
    endtask

    task automatic cyc_b(input string tag, input logic exp_stall, input exp_t e);
        exp_t x;
        #1;
        chk({tag, "_stall"}, 64'(b_stall), 64'(exp_stall));
        qb.push_back(e);
        @(posedge clk);
        #1;
        x = qb.pop_front();
        cmp(tag, x, b_wbv, b_rw, b_rd, b_wd, b_mis, b_err);
    endtask

    task automatic set_a(input logic v, input logic ld, input logic [2:0] dm, input logic [1:0] bs,
                         input logic rw, input logic [4:0] r, input logic [1:0] sel,
                         input logic [31:0] wd, input logic rv, input logic [31:0] data);
        a_in_valid = v; a_is_load = ld; a_dm = dm; a_bias = bs; a_rw_in = rw;
        a_rd_in = r; a_wdsel = sel; a_wd_in = wd; a_rvalid = rv; a_rdata = data;
        a_flush = 1'b0;
    endtask

    task automatic set_b(input logic v, input logic ld, input logic [2:0] dm, input logic [2:0] bs,
                         input logic [4:0] r, input logic rv, input logic [63:0] data);
        b_in_valid = v; b_is_load = ld; b_dm = dm; b_bias = bs; b_rw_in = 1'b1;
        b_rd_in = r; b_wdsel = 2'b01; b_wd_in = 64'h0; b_rvalid = rv; b_rdata = data;
        b_flush = 1'b0;
    endtask

    initial begin
        set_a(1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 32'h0);
        set_b(1'b0, 1'b0, 3'b000, 3'd0, 5'd0, 1'b0, 64'h0);
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        a_rst = 1'b1;
        b_rst = 1'b1;
        #2;
        // reset state, before any clock edge
        chk("rst_wb_valid", 64'(a_wbv), 64'd0);
        chk("rst_RegWrite", 64'(a_rw), 64'd0);
        chk("rst_rd", 64'(a_rd), 64'd0);
        chk("rst_WD", 64'(a_wd), 64'd0);
        chk("rst_mis_align", 64'(a_mis), 64'd0);
        chk("rst_bus_err", 64'(a_err), 64'd0);
        chk("rst_stall", 64'(a_stall), 64'd0);
        @(negedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        b_rst = 1'b0;
        @(posedge clk);
        #1;

        // lb, bias 1
        set_a(1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 5'd5, 2'b01, 32'hAAAA, 1'b1, 32'h1234_80FF);
        cyc_a("lb", 1'b0, mk(1'b1, 1'b1, 5'd5, 64'hFFFF_FF80, 1'b0, 1'b0));
        // lhu, bias 2
        set_a(1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 5'd6, 2'b01, 32'hAAAA, 1'b1, 32'h1234_80FF);
        cyc_a("lhu", 1'b0, mk(1'b1, 1'b1, 5'd6, 64'h0000_1234, 1'b0, 1'b0));
        // misaligned lw: no register write, one-cycle pulse
        set_a(1'b1, 1'b1, 3'b000, 2'd2, 1'b1, 5'd7, 2'b01, 32'hAAAA, 1'b1, 32'h1234_80FF);
        cyc_a("lw_mis", 1'b0, mk(1'b1, 1'b0, 5'd7, 64'h0000_1234, 1'b1, 1'b0));
        // ALU op after it: pulse gone, WD_in selected
        set_a(1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 5'd9, 2'b00, 32'h55, 1'b0, 32'h0);
        cyc_a("alu1", 1'b0, mk(1'b1, 1'b1, 5'd9, 64'h55, 1'b0, 1'b0));
        // flush of a valid ALU op in IDLE
        set_a(1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 5'd8, 2'b00, 32'h77, 1'b0, 32'h0);
        a_flush = 1'b1;
        cyc_a("idle_flush", 1'b0, bub(1'b0));

        // lw with data 3 cycles late
        set_a(1'b1, 1'b1, 3'b000, 2'd0, 1'b1, 5'd10, 2'b01, 32'h0, 1'b0, 32'h0);
        cyc_a("lw_w0", 1'b1, bub(1'b0));
        a_dm = 3'b010;  // captured control must be used while waiting
        a_rd_in = 5'd31;
        cyc_a("lw_w1", 1'b1, bub(1'b0));
        cyc_a("lw_w2", 1'b1, bub(1'b0));
        a_rvalid = 1'b1;
        a_rdata = 32'hDEAD_BEEF;
        cyc_a("lw_arr", 1'b0, mk(1'b1, 1'b1, 5'd10, 64'hDEAD_BEEF, 1'b0, 1'b0));
        set_a(1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc_a("lw_idle", 1'b0, bub(1'b0));

        // timeout: 15 stall cycles, then a single bus_err pulse
        set_a(1'b1, 1'b1, 3'b000, 2'd0, 1'b1, 5'd12, 2'b01, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 15; i++) cyc_a("to_wait", 1'b1, bub(1'b0));
        cyc_a("to_err", 1'b0, bub(1'b1));
        set_a(1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 32'h0);
        cyc_a("to_after", 1'b0, bub(1'b0));

        // flush at wait cycle 2, then an ALU op retires normally
        set_a(1'b1, 1'b1, 3'b000, 2'd0, 1'b1, 5'd13, 2'b01, 32'h0, 1'b0, 32'h0);
        cyc_a("fl_w0", 1'b1, bub(1'b0));
        cyc_a("fl_w1", 1'b1, bub(1'b0));
        a_flush = 1'b1;
        cyc_a("fl_flush", 1'b0, bub(1'b0));
        set_a(1'b1, 1'b0, 3'b000, 2'd0, 1'b1, 5'd14, 2'b00, 32'h55, 1'b0, 32'h0);
        cyc_a("fl_alu", 1'b0, mk(1'b1, 1'b1, 5'd14, 64'h55, 1'b0, 1'b0));
        set_a(1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 32'h0);

        // 64-bit: word unsigned, word signed, dword, misaligned dword
        set_b(1'b1, 1'b1, 3'b110, 3'd4, 5'd3, 1'b1, 64'h8000_0001_0000_0000);
        cyc_b("b_lwu", 1'b0, mk(1'b1, 1'b1, 5'd3, 64'h0000_0000_8000_0001, 1'b0, 1'b0));
        set_b(1'b1, 1'b1, 3'b000, 3'd4, 5'd4, 1'b1, 64'h8000_0001_0000_0000);
        cyc_b("b_lw", 1'b0, mk(1'b1, 1'b1, 5'd4, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b0));
        set_b(1'b1, 1'b1, 3'b101, 3'd0, 5'd11, 1'b1, 64'h8000_0001_0000_0000);
        cyc_b("b_ld", 1'b0, mk(1'b1, 1'b1, 5'd11, 64'h8000_0001_0000_0000, 1'b0, 1'b0));
        set_b(1'b1, 1'b1, 3'b101, 3'd4, 5'd12, 1'b1, 64'h8000_0001_0000_0000);
        cyc_b("b_ld_mis", 1'b0, mk(1'b1, 1'b0, 5'd12, 64'h0000_0000_8000_0001, 1'b1, 1'b0));

        // load enters WAIT, then async reset mid-cycle
        set_b(1'b1, 1'b1, 3'b000, 3'd0, 5'd13, 1'b0, 64'h0);
        cyc_b("b_w0", 1'b1, bub(1'b0));
        #1;
        b_in_valid = 1'b0;
        b_rst = 1'b1;
        #1;
        chk("b_arst_wb_valid", 64'(b_wbv), 64'd0);
        chk("b_arst_RegWrite", 64'(b_rw), 64'd0);
        chk("b_arst_rd", 64'(b_rd), 64'd0);
        chk("b_arst_WD", b_wd, 64'd0);
        chk("b_arst_mis_align", 64'(b_mis), 64'd0);
        chk("b_arst_bus_err", 64'(b_err), 64'd0);
        chk("b_arst_stall", 64'(b_stall), 64'd0);
        @(negedge clk);
        b_rst = 1'b0;
        @(posedge clk);
        #1;
        // late data for the discarded load must not retire anything
        set_b(1'b0, 1'b0, 3'b000, 3'd0, 5'd0, 1'b1, 64'h1234);
        cyc_b("b_ghost", 1'b0, mk(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
